// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared widths and FSM state type for the multiply engine scheduler
package mul_pkg;
  localparam int A_W   = 24;
  localparam int W_W   = 32;
  localparam int L_W   = 6;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;
endpackage

// File: rtl/mul_engine_scheduler_if.sv
// rtl/mul_engine_scheduler_if.sv - start/done bus between the scheduler and the shared engine
interface mul_engine_scheduler_if;
  import mul_pkg::*;

  logic           eng_start;
  logic [A_W-1:0] eng_a1;
  logic [A_W-1:0] eng_a2;
  logic           eng_busy;
  logic           eng_done;
  logic [W_W-1:0] eng_w;
  logic [L_W-1:0] eng_l;
  logic           eng_ovf;

  modport master (
    output eng_start, eng_a1, eng_a2,
    input  eng_busy, eng_done, eng_w, eng_l, eng_ovf
  );

  modport slave (
    input  eng_start, eng_a1, eng_a2,
    output eng_busy, eng_done, eng_w, eng_l, eng_ovf
  );
endinterface

// File: rtl/mul_engine_scheduler_rr_arbiter.sv
// rtl/mul_engine_scheduler_rr_arbiter.sv - combinational round-robin grant, searching upward from last_grant
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant
);
  localparam logic [IW:0] N_V = (IW+1)'(N);

  logic [IW:0]   sum;
  logic [IW-1:0] idx;
  logic          found;

  // Wrap is done by subtraction so non-power-of-two N works.
  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int off = 1; off <= N; off++) begin
      sum = {1'b0, last_grant} + (IW+1)'(off);
      idx = (sum >= N_V) ? IW'(sum - N_V) : IW'(sum);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mul_engine_scheduler.sv
// rtl/mul_engine_scheduler.sv - shares one multiply/popcount engine between N_REQ requesters
module mul_engine_scheduler
  import mul_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                   clk,
  input  logic                   n_reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*A_W-1:0]   req_a1,
  input  logic [N_REQ*A_W-1:0]   req_a2,
  output logic [N_REQ-1:0]       ack,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [W_W-1:0]         rsp_w,
  output logic [L_W-1:0]         rsp_l,
  output logic                   rsp_ovf,
  output logic                   rsp_err,
  mul_engine_scheduler_if.master eng,
  output logic [CNT_W-1:0]       op_count,
  output logic                   busy
);
  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [IW-1:0] LAST_RST = IW'(N_REQ - 1);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYC - 1);

  state_t           state, state_nxt;
  logic [IW-1:0]    last_grant, gnt_idx, sel_idx;
  logic [N_REQ-1:0] grant, gnt_q;
  logic [A_W-1:0]   sel_a1, sel_a2;
  logic [TW-1:0]    timer;
  logic             take, timeout;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .req        (req),
    .last_grant (last_grant),
    .grant      (grant)
  );

  always_comb begin
    sel_idx = '0;
    sel_a1  = '0;
    sel_a2  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_idx = IW'(i);
        sel_a1  = req_a1[i*A_W +: A_W];
        sel_a2  = req_a2[i*A_W +: A_W];
      end
    end
  end

  assign take    = (|req) && !eng.eng_busy;
  assign timeout = (timer == T_LAST);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (take) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (eng.eng_done || timeout) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs; result fields change only when WAIT exits and then hold.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      ack           <= '0;
      rsp_valid     <= '0;
      rsp_w         <= '0;
      rsp_l         <= '0;
      rsp_ovf       <= 1'b0;
      rsp_err       <= 1'b0;
      eng.eng_start <= 1'b0;
      eng.eng_a1    <= '0;
      eng.eng_a2    <= '0;
      op_count      <= '0;
      busy          <= 1'b0;
      last_grant    <= LAST_RST;
      gnt_q         <= '0;
      gnt_idx       <= '0;
      timer         <= '0;
    end else begin
      ack           <= '0;
      rsp_valid     <= '0;
      eng.eng_start <= 1'b0;
      busy          <= (state_nxt != S_IDLE);
      case (state)
        S_IDLE: begin
          if (take) begin
            ack        <= grant;
            gnt_q      <= grant;
            gnt_idx    <= sel_idx;
            eng.eng_a1 <= sel_a1;
            eng.eng_a2 <= sel_a2;
          end
        end
        S_ISSUE: begin
          eng.eng_start <= 1'b1;
          timer         <= '0;
        end
        S_WAIT: begin
          timer <= timer + TW'(1);
          if (eng.eng_done) begin
            rsp_w   <= eng.eng_w;
            rsp_l   <= eng.eng_l;
            rsp_ovf <= eng.eng_ovf;
            rsp_err <= 1'b0;
          end else if (timeout) begin
            rsp_w   <= '0;
            rsp_l   <= '0;
            rsp_ovf <= 1'b0;
            rsp_err <= 1'b1;
          end
        end
        S_RESP: begin
          rsp_valid  <= gnt_q;
          op_count   <= op_count + CNT_W'(1);
          last_grant <= gnt_idx;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_engine_scheduler.sv
// tb/tb_mul_engine_scheduler.sv - randomized self-checking bench with behavioural engine and scheduler model
module tb_mul_engine_scheduler;
  import mul_pkg::*;

  localparam int N  = 3;
  localparam int TO = 64;

  logic                 clk     = 1'b0;
  logic                 n_reset = 1'b0;
  logic [N-1:0]         req     = '0;
  logic [N*A_W-1:0]     req_a1  = '0;
  logic [N*A_W-1:0]     req_a2  = '0;
  logic [N-1:0]         ack, rsp_valid;
  logic [W_W-1:0]       rsp_w;
  logic [L_W-1:0]       rsp_l;
  logic                 rsp_ovf, rsp_err;
  logic [CNT_W-1:0]     op_count;
  logic                 busy;

  mul_engine_scheduler_if eng ();

  mul_engine_scheduler #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .n_reset(n_reset), .req(req), .req_a1(req_a1), .req_a2(req_a2),
    .ack(ack), .rsp_valid(rsp_valid), .rsp_w(rsp_w), .rsp_l(rsp_l),
    .rsp_ovf(rsp_ovf), .rsp_err(rsp_err), .eng(eng), .op_count(op_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural engine: done pulse lat cycles after start; lat 0 never answers.
  int lat_cfg = 3;
  bit lat_rand = 1'b0;
  int lat_tab [8] = '{1, 2, 3, 5, 8, 63, 64, 0};

  initial begin : engine
    int cnt;
    bit pend;
    logic [A_W-1:0] ea1, ea2;
    logic [47:0] p;
    cnt = 0; pend = 1'b0; ea1 = '0; ea2 = '0; p = '0;
    eng.eng_done = 1'b0; eng.eng_w = '0; eng.eng_l = '0; eng.eng_ovf = 1'b0;
    forever begin
      @(posedge clk); #1;
      eng.eng_done = 1'b0;
      eng.eng_w    = $urandom;
      eng.eng_l    = 6'($urandom);
      eng.eng_ovf  = 1'($urandom);
      if (!n_reset) pend = 1'b0;
      else if (pend) begin
        cnt--;
        if (cnt == 0) begin
          pend         = 1'b0;
          p            = {24'b0, ea1} * {24'b0, ea2};
          eng.eng_w    = p[31:0];
          eng.eng_l    = 6'($countones(p[31:0]));
          eng.eng_ovf  = |p[47:32];
          eng.eng_done = 1'b1;
        end
      end
      if (eng.eng_start) begin
        ea1  = eng.eng_a1;
        ea2  = eng.eng_a2;
        cnt  = lat_rand ? lat_tab[$urandom_range(7)] : lat_cfg;
        pend = (cnt != 0);
      end
    end
  end

  function automatic int rr(input logic [N-1:0] r, input int last);
    for (int off = 1; off <= N; off++)
      if (r[(last + off) % N]) return (last + off) % N;
    return -1;
  endfunction

  int ack_log[$];

  // Scheduler model: transaction-level timing rules, checked every cycle.
  initial begin : model
    bit               inflight;
    int               m_last, m_g, cyc, t_start, t_exit, g;
    logic [A_W-1:0]   m_a1, m_a2;
    logic [47:0]      p;
    logic [W_W-1:0]   h_w;
    logic [L_W-1:0]   h_l;
    logic             h_ovf, h_err;
    logic [CNT_W-1:0] m_cnt;
    logic [N-1:0]     req_s, exp_ack, exp_rv;
    logic [N*A_W-1:0] a1_s, a2_s;
    logic             ebusy_s, done_s, exp_start;
    inflight = 0; m_last = N-1; m_g = 0; cyc = 0; t_start = -1; t_exit = -1; g = 0;
    m_a1 = '0; m_a2 = '0; p = '0; h_w = '0; h_l = '0; h_ovf = 0; h_err = 0; m_cnt = '0;
    req_s = '0; a1_s = '0; a2_s = '0; ebusy_s = 0; done_s = 0;
    forever begin
      @(negedge clk);
      cyc++;
      exp_ack = '0; exp_rv = '0; exp_start = 1'b0;
      if (!n_reset) begin
        inflight = 0; m_last = N-1; m_cnt = '0; t_start = -1; t_exit = -1;
        h_w = '0; h_l = '0; h_ovf = 0; h_err = 0;
        chk("rst_eng_a1", eng.eng_a1, 0);
      end else if (!inflight) begin
        if ((|req_s) && !ebusy_s) begin
          g = rr(req_s, m_last);
          exp_ack[g] = 1'b1;
          inflight = 1; m_g = g;
          m_a1 = a1_s[g*A_W +: A_W];
          m_a2 = a2_s[g*A_W +: A_W];
          t_start = cyc + 1; t_exit = -1;
        end
      end else if (cyc == t_start) begin
        exp_start = 1'b1;
      end else if (t_exit < 0) begin
        if (done_s) begin
          p = {24'b0, m_a1} * {24'b0, m_a2};
          h_w = p[31:0]; h_l = 6'($countones(p[31:0])); h_ovf = |p[47:32]; h_err = 0;
          t_exit = cyc;
        end else if (cyc - t_start == TO) begin
          h_w = '0; h_l = '0; h_ovf = 0; h_err = 1;
          t_exit = cyc;
        end
      end else begin
        exp_rv[m_g] = 1'b1;
        m_cnt++;
        m_last = m_g;
        inflight = 0;
      end
      chk("ack", ack, exp_ack);
      chk("rsp_valid", rsp_valid, exp_rv);
      chk("eng_start", eng.eng_start, exp_start);
      chk("busy", busy, inflight);
      chk("op_count", op_count, m_cnt);
      chk("rsp_w", rsp_w, h_w);
      chk("rsp_l", rsp_l, h_l);
      chk("rsp_ovf", rsp_ovf, h_ovf);
      chk("rsp_err", rsp_err, h_err);
      if (inflight && n_reset) begin
        chk("eng_a1", eng.eng_a1, m_a1);
        chk("eng_a2", eng.eng_a2, m_a2);
      end
      for (int i = 0; i < N; i++) if (ack[i]) ack_log.push_back(i);
      req_s = req; a1_s = req_a1; a2_s = req_a2;
      ebusy_s = eng.eng_busy; done_s = eng.eng_done;
    end
  end

  bit rnd = 1'b0;
  logic [N-1:0] hold = '0;

  function automatic logic [A_W-1:0] opnd();
    case ($urandom_range(5))
      0:       return '0;
      1:       return 24'hFFFFFF;
      2:       return 24'd1;
      default: return 24'($urandom);
    endcase
  endfunction

  task automatic step(input int n);
    for (int s = 0; s < n; s++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (req[i] && ack[i] && !hold[i]) req[i] = 1'b0;
        if (rnd) begin
          if (req[i]) begin
            if ($urandom_range(31) == 0) req[i] = 1'b0;
          end else if ($urandom_range(3) == 0) begin
            req_a1[i*A_W +: A_W] = opnd();
            req_a2[i*A_W +: A_W] = opnd();
            req[i] = 1'b1;
          end
        end
      end
      if (rnd) eng.eng_busy = ($urandom_range(7) == 0);
    end
  endtask

  task automatic raise(input int i, input logic [A_W-1:0] a, input logic [A_W-1:0] b);
    req_a1[i*A_W +: A_W] = a;
    req_a2[i*A_W +: A_W] = b;
    req[i] = 1'b1;
  endtask

  task automatic wait_rsp(input int i, input int max, input string name);
    bit ok;
    ok = 0;
    for (int s = 0; s < max && !ok; s++) begin
      step(1);
      if (rsp_valid[i]) ok = 1;
    end
    chk(name, ok, 1);
  endtask

  task automatic wait_cnt(input int v, input int max, input string name);
    bit ok;
    ok = 0;
    for (int s = 0; s < max && !ok; s++) begin
      step(1);
      if (op_count == CNT_W'(v)) ok = 1;
    end
    chk(name, ok, 1);
  endtask

  initial begin : stim
    int n, st;
    bit ok;
    eng.eng_busy = 1'b0;
    step(3);
    n_reset = 1'b1;
    step(2);

    // Two requesters held high alternate starting from requester 0.
    hold = 3'b011;
    raise(0, 24'd3, 24'd5);
    raise(1, 24'd10, 24'd20);
    wait_cnt(4, 200, "t3_done");
    req = '0; hold = '0;
    step(3);
    chk("t3_nacks", ack_log.size(), 4);
    if (ack_log.size() >= 4) begin
      chk("t3_g0", ack_log[0], 0);
      chk("t3_g1", ack_log[1], 1);
      chk("t3_g2", ack_log[2], 0);
      chk("t3_g3", ack_log[3], 1);
    end

    ack_log.delete();
    raise(0, 24'd3, 24'd5);
    wait_rsp(0, 40, "t1_rsp");
    chk("t1_w", rsp_w, 32'd15);
    chk("t1_l", rsp_l, 4);
    chk("t1_ovf", rsp_ovf, 0);
    chk("t1_err", rsp_err, 0);
    chk("t1_cnt", op_count, 5);
    chk("t1_nacks", ack_log.size(), 1);

    raise(0, 24'hFFFFFF, 24'hFFFFFF);
    wait_rsp(0, 40, "t2_rsp");
    chk("t2_w", rsp_w, 32'hFE000001);
    chk("t2_l", rsp_l, 8);
    chk("t2_ovf", rsp_ovf, 1);

    // Engine never answers.
    lat_cfg = 0;
    raise(0, 24'd7, 24'd9);
    ok = 0;
    for (int s = 0; s < 10 && !ok; s++) begin
      step(1);
      if (eng.eng_start) ok = 1;
    end
    chk("t4_start", ok, 1);
    n = 0;
    while (!rsp_err && n < 100) begin
      step(1);
      n++;
    end
    chk("t4_timeout_cycles", n, TO);
    chk("t4_w", rsp_w, 0);
    step(1);
    chk("t4_cnt", op_count, 7);
    lat_cfg = 3;
    raise(1, 24'd100, 24'd200);
    wait_rsp(1, 40, "t4_next_rsp");
    chk("t4_next_w", rsp_w, 32'd20000);
    chk("t4_next_err", rsp_err, 0);

    // Engine busy blocks issue.
    ack_log.delete();
    eng.eng_busy = 1'b1;
    raise(0, 24'd2, 24'd2);
    st = 0;
    for (int s = 0; s < 10; s++) begin
      step(1);
      if (eng.eng_start || (ack != 0)) st++;
    end
    chk("t5_quiet", st, 0);
    eng.eng_busy = 1'b0;
    wait_rsp(0, 40, "t5_rsp");
    chk("t5_w", rsp_w, 32'd4);
    chk("t5_cnt", op_count, 9);

    // Reset during WAIT.
    lat_cfg = 20;
    raise(1, 24'd5, 24'd5);
    ok = 0;
    for (int s = 0; s < 10 && !ok; s++) begin
      step(1);
      if (eng.eng_start) ok = 1;
    end
    chk("t6_start", ok, 1);
    step(5);
    n_reset = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_cnt0", op_count, 0);
    chk("t6_ack", ack, 0);
    chk("t6_eng_a1", eng.eng_a1, 0);
    step(2);
    n_reset = 1'b1;
    lat_cfg = 3;
    ack_log.delete();
    raise(0, 24'd6, 24'd7);
    raise(1, 24'd8, 24'd9);
    ok = 0;
    for (int s = 0; s < 10 && !ok; s++) begin
      step(1);
      if (ack_log.size() > 0) ok = 1;
    end
    chk("t6_grant_seen", ok, 1);
    if (ok) chk("t6_first_grant", ack_log[0], 0);
    wait_cnt(2, 100, "t6_drain");

    // Randomized traffic against the model.
    lat_rand = 1'b1;
    rnd = 1'b1;
    step(3000);
    rnd = 1'b0;
    req = '0;
    eng.eng_busy = 1'b0;
    step(200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
